// File: rtl/halt_rst_ctrl.sv
// Halt/reset controller: synchronises reset release, holds fetch idle for a
// boot window, then on an accepted HLT freezes fetch, drains the pipeline and
// raises a sticky hlt until the next reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RESET   | boot window; waits RST_HOLD edges of synced reset release
// RUN     | normal fetch; watches for an unstalled, unflushed HLT in ID
// DRAIN   | fetch frozen; counting down PIPE_DEPTH stages after ID
// HALTED  | pipeline empty, hlt asserted; only rst_n leaves this state
module halt_rst_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int RST_HOLD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hlt_dec,
    input  logic       stall_in,
    input  logic       flush_in,
    output logic       rst_sync_n,
    output logic       pc_en,
    output logic       if_squash,
    output logic       hlt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [3:0] HOLD_LAST  = 4'(RST_HOLD - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_DEPTH - 1);

    logic [1:0] sync_q;
    state_e     state_q;
    logic [3:0] cnt_q;
    logic       hlt_q;
    logic       accept;

    // Reset synchroniser: asserts asynchronously, releases two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[1];

    // An HLT is taken only when it will really advance out of ID.
    assign accept = (state_q == ST_RUN) & hlt_dec & ~stall_in & ~flush_in;

    // Sequencer: boot hold, HLT acceptance, drain countdown and sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= 4'd0;
            hlt_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_sync_n) begin
                        // Saturating compare so an out-of-range count cannot wrap.
                        if (cnt_q >= HOLD_LAST) begin
                            state_q <= ST_RUN;
                            cnt_q   <= 4'd0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_HALTED;
                        hlt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HALTED: begin
                    hlt_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RESET;
                    cnt_q   <= 4'd0;
                    hlt_q   <= 1'b0;
                end
            endcase
        end
    end

    // Fetch runs only in RUN, and is held for the cycle an HLT is accepted.
    assign pc_en     = (state_q == ST_RUN) & ~accept;
    assign if_squash = ~pc_en;
    assign hlt       = hlt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_halt_rst_ctrl.sv
// Scoreboard bench for halt_rst_ctrl: stimulus pushes hand-computed expected
// output vectors {rst_sync_n, pc_en, if_squash, hlt, state}; a monitor pops
// one per cycle at the falling edge and compares.
module tb_halt_rst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       hlt_dec;
    logic       stall_in;
    logic       flush_in;
    logic       rst_sync_n;
    logic       pc_en;
    logic       if_squash;
    logic       hlt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];
    bit         stim_done = 1'b0;

    //                          rsn pc  sq  hlt state
    localparam logic [5:0] RST_V = {1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    localparam logic [5:0] BOOT_V = {1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    localparam logic [5:0] RUN_V = {1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    localparam logic [5:0] ACC_V = {1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    localparam logic [5:0] DRN_V = {1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
    localparam logic [5:0] HLT_V = {1'b1, 1'b0, 1'b1, 1'b1, 2'd3};

    halt_rst_ctrl #(.PIPE_DEPTH(3), .RST_HOLD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hlt_dec    (hlt_dec),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .rst_sync_n (rst_sync_n),
        .pc_en      (pc_en),
        .if_squash  (if_squash),
        .hlt        (hlt),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: drive just after the rising edge, queue the expected outputs.
    task automatic cyc(input logic r, input logic hd, input logic st, input logic fl,
                       input logic [5:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n    = r;
        hlt_dec  = hd;
        stall_in = st;
        flush_in = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Reset held low, then released: sync rises on 2nd edge, RUN two edges later.
    task automatic boot(input int low_cycles);
        for (int i = 0; i < low_cycles; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, RST_V, "reset_low");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, RST_V,  "release_e0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, RST_V,  "release_e1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, BOOT_V, "sync_e2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, BOOT_V, "hold_e3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, RUN_V,  "run_e4");
    endtask

    // Monitor: compare one queued expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            logic [5:0] a;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {rst_sync_n, pc_en, if_squash, hlt, state};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got rsn/pc/sq/hlt/st=%b expected %b at %0t", nm, a, e, $time);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        hlt_dec  = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;

        // Test 1: boot sequence
        boot(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, RUN_V, "run_idle");

        // Test 2: single-cycle HLT, drain of 3, sticky halt
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ACC_V, "accept_e0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "drain1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "drain2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "drain3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HLT_V, "halt_e3");
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, HLT_V, "halt_hold");

        // Test 6: inputs toggled while halted
        for (int i = 0; i < 50; i++)
            cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                HLT_V, "halt_random");

        // Reset from HALTED drops hlt immediately
        cyc(1'b0, 1'b0, 1'b0, 1'b0, RST_V, "halt_async_rst");
        boot(1);

        // Test 3: HLT held off by stall, accepted when stall clears
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, RUN_V, "stall_hold");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ACC_V, "stall_release");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "stall_drain1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "stall_drain2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "stall_drain3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HLT_V, "stall_halt");

        cyc(1'b0, 1'b0, 1'b0, 1'b0, RST_V, "halt_async_rst2");
        boot(1);

        // Test 4: flushed HLT is ignored
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, RUN_V, "flush_hlt");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, RUN_V, "flush_stall_hlt");
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, RUN_V, "flush_no_hlt");

        // Test 5: reset pulse mid-drain (counter=1), boot repeats
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ACC_V, "mid_accept");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, DRN_V, "mid_drain_cnt2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, RST_V, "mid_drain_rst");
        boot(1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, RUN_V, "reboot_run");

        stim_done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stim_done=%0d expected 1", stim_done);
        $fatal(1, "timeout");
    end

endmodule
